// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
// One request in flight; the response returns on a later cycle with im_rvalid.
interface if_fetch_unit_if #(
  parameter int unsigned DATA_SIZE = 32
);
  logic                 im_req;
  logic [DATA_SIZE-1:0] im_addr;
  logic                 im_gnt;
  logic                 im_rvalid;
  logic [DATA_SIZE-1:0] im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_gnt,
    input  im_rvalid,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_gnt,
    output im_rvalid,
    output im_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding memory fetch FSM,
// one-entry skid buffer for decode back-pressure, and the IF/ID register.
module if_fetch_unit #(
  parameter int unsigned          DATA_SIZE = 32,
  parameter logic [DATA_SIZE-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] pc_data,
  input  logic                 flush,
  input  logic                 id_stall,
  output logic [DATA_SIZE-1:0] pc,
  output logic [DATA_SIZE-1:0] next_pc,
  output logic                 fetch_stall,
  output logic                 if_valid,
  output logic [DATA_SIZE-1:0] if_instr,
  output logic [DATA_SIZE-1:0] if_pc,
  if_fetch_unit_if.master      im
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_SIZE-1:0] pc_q;
  logic                 if_valid_q, if_valid_d;
  logic [DATA_SIZE-1:0] if_instr_q, if_instr_d;
  logic [DATA_SIZE-1:0] if_pc_q, if_pc_d;
  logic [DATA_SIZE-1:0] skid_instr_q, skid_instr_d;
  logic [DATA_SIZE-1:0] skid_pc_q, skid_pc_d;
  logic                 deliver;

  always_comb begin
    state_d      = state_q;
    if_valid_d   = id_stall ? if_valid_q : 1'b0;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    deliver      = 1'b0;

    if (flush) begin
      // A granted or pending request must still be drained so that only one
      // response is ever outstanding; a response arriving now is simply dropped.
      if_valid_d   = 1'b0;
      skid_instr_d = '0;
      skid_pc_d    = '0;
      unique case (state_q)
        REQ:     state_d = im.im_gnt    ? DRAIN : REQ;
        WAIT:    state_d = im.im_rvalid ? REQ   : DRAIN;
        DRAIN:   state_d = im.im_rvalid ? REQ   : DRAIN;
        default: state_d = REQ;
      endcase
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (im.im_gnt) state_d = WAIT;
        end
        WAIT: begin
          if (im.im_rvalid) begin
            if (!id_stall) begin
              deliver    = 1'b1;
              if_valid_d = 1'b1;
              if_instr_d = im.im_rdata;
              if_pc_d    = pc_q;
              state_d    = REQ;
            end else begin
              skid_instr_d = im.im_rdata;
              skid_pc_d    = pc_q;
              state_d      = HOLD;
            end
          end
        end
        HOLD: begin
          if (!id_stall) begin
            deliver    = 1'b1;
            if_valid_d = 1'b1;
            if_instr_d = skid_instr_q;
            if_pc_d    = skid_pc_q;
            state_d    = REQ;
          end
        end
        DRAIN: begin
          if (im.im_rvalid) state_d = REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_data;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign pc          = pc_q;
  assign next_pc     = pc_q + DATA_SIZE'(4);
  assign fetch_stall = !(flush || (deliver && !rst));
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign im.im_req   = (state_q == REQ) && !rst;
  assign im.im_addr  = pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by random
// traffic, compared cycle by cycle against a transaction-level fetch model.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc_data;
  logic        flush;
  logic        id_stall;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        fetch_stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  if_fetch_unit_if #(.DATA_SIZE(32)) imif ();

  if_fetch_unit #(
    .DATA_SIZE(32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_data    (pc_data),
    .flush      (flush),
    .id_stall   (id_stall),
    .pc         (pc),
    .next_pc    (next_pc),
    .fetch_stall(fetch_stall),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .im         (imif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          chk_en = 1'b0;

  // Model: fetch progress as transaction facts rather than FSM states.
  logic [31:0] m_pc;
  bit          m_started;   // first cycle after reset has passed
  bit          m_out;       // a granted request awaits its response
  bit          m_drop;      // that response must be discarded
  bit          m_skid;      // a response is parked waiting for decode
  logic [31:0] m_skid_instr, m_skid_pc;
  bit          m_v;
  logic [31:0] m_instr, m_ipc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit f, input logic [31:0] tgt, input bit st,
                     input bit g, input bit rv, input logic [31:0] rd);
    bit e_req, dlv, e_fs;
    e_req = !r && m_started && !m_out && !m_skid;
    dlv   = !r && !f && !st && ((m_out && !m_drop && rv) || m_skid);
    e_fs  = !(f || dlv);
    rst             = r;
    flush           = f;
    id_stall        = st;
    imif.im_gnt     = g;
    imif.im_rvalid  = rv;
    imif.im_rdata   = rd;
    pc_data         = f ? tgt : (e_fs ? m_pc : m_pc + 32'd4);
    #2;
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("next_pc", next_pc, m_pc + 32'd4);
      chk("fetch_stall", {31'd0, fetch_stall}, {31'd0, e_fs});
      chk("im_req", {31'd0, imif.im_req}, {31'd0, e_req});
      chk("im_addr", imif.im_addr, m_pc);
      chk("if_valid", {31'd0, if_valid}, {31'd0, m_v});
      chk("if_instr", if_instr, m_instr);
      chk("if_pc", if_pc, m_ipc);
    end
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_started = 0; m_out = 0; m_drop = 0; m_skid = 0;
      m_skid_instr = 0; m_skid_pc = 0; m_v = 0; m_instr = 0; m_ipc = 0;
    end else begin
      if (!st || f) m_v = 0;
      if (f) begin
        m_skid = 0; m_skid_instr = 0; m_skid_pc = 0;
        if (!m_started) m_started = 1;
        else if (e_req && g) begin m_out = 1; m_drop = 1; end
        else if (m_out) begin
          if (rv) begin m_out = 0; m_drop = 0; end
          else m_drop = 1;
        end
      end else if (!m_started) begin
        m_started = 1;
      end else if (e_req && g) begin
        m_out = 1; m_drop = 0;
      end else if (m_out && rv) begin
        m_out = 0;
        if (m_drop) m_drop = 0;
        else if (!st) begin m_v = 1; m_instr = rd; m_ipc = m_pc; end
        else begin m_skid = 1; m_skid_instr = rd; m_skid_pc = m_pc; end
      end else if (m_skid && !st) begin
        m_v = 1; m_instr = m_skid_instr; m_ipc = m_skid_pc; m_skid = 0;
      end
      m_pc = pc_data;
    end
    chk_en = 1'b1;
    #1;
  endtask

  initial begin
    bit r, f, st, g, rv;
    logic [31:0] tgt;
    rst = 1'b1; flush = 1'b0; id_stall = 1'b0; pc_data = '0;
    imif.im_gnt = 1'b0; imif.im_rvalid = 1'b0; imif.im_rdata = '0;
    m_pc = '0; m_started = 0; m_out = 0; m_drop = 0; m_skid = 0;
    m_skid_instr = '0; m_skid_pc = '0; m_v = 0; m_instr = '0; m_ipc = '0;

    // Reset, then first fetch returning 0x13 one cycle after grant.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 32'hCAFE_0000);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("s1_req", {31'd0, imif.im_req}, 32'd1);
    chk("s1_addr", imif.im_addr, 32'h0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h0000_0013);
    chk("s1_valid", {31'd0, if_valid}, 32'd1);
    chk("s1_instr", if_instr, 32'h13);
    chk("s1_ifpc", if_pc, 32'h0);
    chk("s1_next_addr", imif.im_addr, 32'h4);

    // Response under decode stall: parked for three stall cycles.
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 1, 32'hA5A5_0001);
    chk("s2_fetch_stall", {31'd0, fetch_stall}, 32'd1);
    chk("s2_pc", pc, 32'h4);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("s2_pc_held", pc, 32'h4);
    chk("s2_ifid_held", if_instr, 32'h13);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("s2_instr", if_instr, 32'hA5A5_0001);
    chk("s2_ifpc", if_pc, 32'h4);
    chk("s2_pc_adv", pc, 32'h8);

    // Flush while waiting: drain the late response, then fetch from 0x100.
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h100, 0, 0, 0, 0);
    chk("s3_drain_noreq", {31'd0, imif.im_req}, 32'd0);
    cyc(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("s3_dropped", {31'd0, if_valid}, 32'd0);
    chk("s3_addr", imif.im_addr, 32'h100);
    chk("s3_req", {31'd0, imif.im_req}, 32'd1);

    // Flush coincident with the response: no drain.
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h200, 0, 0, 1, 32'hBAD0_0001);
    chk("s4_req", {31'd0, imif.im_req}, 32'd1);
    chk("s4_addr", imif.im_addr, 32'h200);
    chk("s4_valid", {31'd0, if_valid}, 32'd0);

    // Repeated flush while draining keeps draining.
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h300, 0, 0, 0, 0);
    cyc(0, 1, 32'h304, 0, 0, 0, 0);
    chk("s5_still_drain", {31'd0, imif.im_req}, 32'd0);
    cyc(0, 0, 0, 0, 0, 1, 32'h0BAD_0BAD);
    chk("s5_addr", imif.im_addr, 32'h304);

    // PC wrap.
    cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    chk("s6_pc", pc, 32'hFFFF_FFFC);
    chk("s6_next_pc", next_pc, 32'h0);

    // Reset mid-WAIT, then a stray response in IDLE.
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("s7_pc", pc, 32'h0);
    chk("s7_valid", {31'd0, if_valid}, 32'd0);
    chk("s7_instr", if_instr, 32'h0);
    chk("s7_req", {31'd0, imif.im_req}, 32'd0);
    cyc(0, 0, 0, 0, 0, 1, 32'h1234_5678);
    chk("s7_ignored", {31'd0, if_valid}, 32'd0);
    chk("s7_req_after", {31'd0, imif.im_req}, 32'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(59) == 0);
      f   = ($urandom_range(7) == 0);
      tgt = $urandom & 32'hFFFF_FFFC;
      st  = ($urandom_range(2) == 0);
      g   = ($urandom_range(1) == 1);
      rv  = (m_out && $urandom_range(2) == 0) || (!m_started && $urandom_range(1) == 1);
      cyc(r, f, tgt, st, g, rv, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The module SHALL have parameter DATA_SIZE, default 32, meaning the address and instruction width.
REQ-002 The module SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pc_data  input  DATA_SIZE  next PC chosen by the PC-select stage.
REQ-006 flush  input  1  jump taken this cycle; discard all fetch work in flight.
REQ-007 id_stall  input  1  decode cannot accept an instruction this cycle.
REQ-008 im_gnt  input  1  instruction memory accepts the request this cycle.
REQ-009 im_rvalid  input  1  instruction memory returns data this cycle.
REQ-010 im_rdata  input  DATA_SIZE  returned instruction word.
REQ-011 pc  output  DATA_SIZE  current PC register.
REQ-012 next_pc  output  DATA_SIZE  pc+4, combinational.
REQ-013 fetch_stall  output  1  PC hold request to the PC-select stage.
REQ-014 im_req  output  1  fetch request valid.
REQ-015 im_addr  output  DATA_SIZE  fetch address, equal to pc.
REQ-016 if_valid  output  1  IF/ID register holds a valid instruction.
REQ-017 if_instr  output  DATA_SIZE  IF/ID instruction.
REQ-018 if_pc  output  DATA_SIZE  PC of if_instr.

Function
REQ-019 The pc register SHALL load pc_data on every non-reset clock edge.
REQ-020 next_pc SHALL equal pc+4 modulo 2^DATA_SIZE, so 32'hFFFF_FFFC gives 32'h0000_0000.
REQ-021 The FSM SHALL have exactly five states: IDLE, REQ, WAIT, HOLD, DRAIN.
REQ-022 IDLE SHALL drive im_req=0, ignore im_rvalid, and go to REQ on the next edge.
REQ-023 REQ SHALL drive im_req=1 with im_addr=pc, and go to WAIT on im_gnt=1; otherwise it stays in REQ.
REQ-024 In WAIT, when im_rvalid=1 and id_stall=0, the unit SHALL load if_instr<=im_rdata, if_pc<=pc and if_valid<=1, then go to REQ.
REQ-025 In WAIT, when im_rvalid=1 and id_stall=1, the unit SHALL capture im_rdata and pc into a one-entry skid buffer and go to HOLD.
REQ-026 In HOLD, when id_stall=0, the unit SHALL move the skid buffer into IF/ID with if_valid<=1 and go to REQ; otherwise it stays in HOLD.
REQ-027 Whenever id_stall=1, if_valid, if_instr and if_pc SHALL hold their values.
REQ-028 Whenever id_stall=0 and no instruction is delivered that cycle, if_valid SHALL be cleared.
REQ-029 fetch_stall SHALL be 0 only when flush=1, or in the cycle an instruction is delivered into IF/ID; it SHALL be 1 at all other times, including in IDLE.
REQ-030 flush SHALL take priority over id_stall and over all FSM rules, and SHALL clear if_valid and the skid buffer on the next edge.
REQ-031 On flush, from IDLE, HOLD, REQ without im_gnt, or WAIT with im_rvalid=1 (response dropped), the next state SHALL be REQ.
REQ-032 On flush, from REQ with im_gnt=1, or WAIT with im_rvalid=0, the next state SHALL be DRAIN.
REQ-033 DRAIN SHALL drive im_req=0, discard the response on im_rvalid=1 and go to REQ; a flush while in DRAIN SHALL keep the state in DRAIN until the response arrives.
REQ-034 At most one memory request SHALL be outstanding at any time.

Reset
REQ-035 When rst=1 at a clock edge, the unit SHALL set pc=RESET_PC, state=IDLE, if_valid=0, if_instr=0, if_pc=0 and clear the skid buffer.
REQ-036 While rst=1, im_req SHALL be 0.
REQ-037 Reset in any state, including WAIT or DRAIN, SHALL abandon the outstanding fetch without waiting for a response.

Verification
REQ-038 Scenario: reset release, memory with im_gnt=1 and im_rvalid one cycle after the grant, returning 32'h0000_0013 -> im_req=1 and im_addr=0 in the 2nd cycle after reset; if_valid=1, if_instr=32'h13, if_pc=0 one cycle after im_rvalid; next fetch address 4.
REQ-039 Scenario: im_rvalid arrives with id_stall=1 for 3 cycles -> the unit enters HOLD; fetch_stall=1 and pc is unchanged; the instruction reaches IF/ID on the edge after id_stall falls.
REQ-040 Scenario: flush with jump address 32'h100 while in WAIT -> DRAIN; the late response is dropped with if_valid=0; the next im_addr is 32'h100.
REQ-041 Scenario: flush in the same cycle as im_rvalid -> data discarded, no DRAIN entered, REQ issued at the jump address next cycle.
REQ-042 Scenario: pc=32'hFFFF_FFFC -> next_pc=32'h0000_0000.
REQ-043 Scenario: rst asserted mid-WAIT -> the state/output reset values of REQ-035 and REQ-036 hold after the edge, and an im_rvalid arriving in IDLE is ignored.
